// File: rtl/calc_pkg.sv
// Shared calculator definitions: FSM state encoding, BCD digit width, digit sizing helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package calc_pkg;

  // Three-phase sequencer encoding, shared with the divider's state machine.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } calc_state_e;

  localparam int BCD_W = 4;

  // Number of decimal digits needed for the largest unsigned value of the given width.
  function automatic int digits_for_bits(input int bits);
    longint unsigned max_v;
    int              n;
    max_v = (longint'(1) << bits) - 1;
    n     = 1;
    for (int i = 0; i < 20; i++) begin
      if (max_v >= 10) begin
        max_v = max_v / 10;
        n     = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
// Latency: combinational.
// Backpressure: none.
// Ports: din - working digit; dout - corrected digit.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter: BITS-wide (optionally signed) value to sign + DIGITS packed BCD digits.
// Latency: BITS+2 cycles from accepted start to the done pulse.
// Backpressure: start is accepted only while ready=1; a start while busy is dropped, nothing is queued.
// Ports: clk/rst_n - clock and async active-low reset; value/start/ready - request side;
//        done - one-cycle result strobe; bcd/neg/overflow - registered result, stable between done pulses.
module bin_to_bcd
  import calc_pkg::*;
#(
  parameter int BITS   = 32,
  parameter int DIGITS = 10,
  parameter int SIGNED = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BITS-1:0]           value,
  input  logic                      start,
  output logic                      ready,
  output logic                      done,
  output logic [BCD_W*DIGITS-1:0]   bcd,
  output logic                      neg,
  output logic                      overflow
);

  localparam int  BCD_TOT   = BCD_W * DIGITS;
  localparam int  CNT_W     = $clog2(BITS + 1);
  localparam bit  IS_SIGNED = (SIGNED != 0);

  calc_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BITS-1:0]      mag_q, mag_d;
  logic [BCD_TOT-1:0]   work_q, work_d;
  logic                 sign_w_q, sign_w_d;
  logic                 ovf_w_q, ovf_w_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic [BCD_TOT-1:0]   bcd_q, bcd_d;
  logic                 neg_q, neg_d;
  logic                 overflow_q, overflow_d;

  logic [BCD_TOT-1:0]   work_adj;
  logic [BITS-1:0]      value_neg;
  logic                 value_is_neg;

  // Two's-complement negate taken as unsigned: the most-negative input maps to 2^(BITS-1) exactly.
  assign value_neg    = ~value + BITS'(1);
  assign value_is_neg = IS_SIGNED & value[BITS-1];

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (work_q[g*BCD_W +: BCD_W]),
      .dout (work_adj[g*BCD_W +: BCD_W])
    );
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    work_d     = work_q;
    sign_w_d   = sign_w_q;
    ovf_w_d    = ovf_w_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mag_d    = value_is_neg ? value_neg : value;
          sign_w_d = value_is_neg;
          work_d   = '0;
          ovf_w_d  = 1'b0;
          cnt_d    = CNT_W'(BITS);
          state_d  = ST_SHIFT;
          ready_d  = 1'b0;
        end
      end

      ST_SHIFT: begin
        // A set top bit after correction would be shifted out of the digit array.
        work_d  = {work_adj[BCD_TOT-2:0], mag_q[BITS-1]};
        mag_d   = {mag_q[BITS-2:0], 1'b0};
        ovf_w_d = ovf_w_q | work_adj[BCD_TOT-1];
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FINISH;
        end
      end

      ST_FINISH: begin
        bcd_d      = work_q;
        neg_d      = sign_w_q;
        overflow_d = ovf_w_q;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
        ready_d    = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      work_q     <= '0;
      sign_w_q   <= 1'b0;
      ovf_w_q    <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      work_q     <= work_d;
      sign_w_q   <= sign_w_d;
      ovf_w_q    <= ovf_w_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
      overflow_q <= overflow_d;
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign neg      = neg_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Bench for bin_to_bcd: three configurations (signed 32/10, unsigned 32/10, unsigned 8/2)
// driven with directed and random values, checked against a decimal arithmetic model.
module tb_bin_to_bcd;

  logic               clk;
  logic               rst_n;
  logic [2:0][31:0]   value_v;
  logic [2:0]         start_v;
  logic [2:0]         ready_v;
  logic [2:0]         done_v;
  logic [2:0]         neg_v;
  logic [2:0]         ovf_v;
  logic [2:0][39:0]   bcd_v;
  logic [7:0]         bcd_s;

  int total;
  int bad;

  assign bcd_v[2] = {32'd0, bcd_s};

  bin_to_bcd #(.BITS(32), .DIGITS(10), .SIGNED(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .value(value_v[0]), .start(start_v[0]),
    .ready(ready_v[0]), .done(done_v[0]), .bcd(bcd_v[0]), .neg(neg_v[0]), .overflow(ovf_v[0])
  );

  bin_to_bcd #(.BITS(32), .DIGITS(10), .SIGNED(0)) u_uns (
    .clk(clk), .rst_n(rst_n), .value(value_v[1]), .start(start_v[1]),
    .ready(ready_v[1]), .done(done_v[1]), .bcd(bcd_v[1]), .neg(neg_v[1]), .overflow(ovf_v[1])
  );

  bin_to_bcd #(.BITS(8), .DIGITS(2), .SIGNED(0)) u_sml (
    .clk(clk), .rst_n(rst_n), .value(value_v[2][7:0]), .start(start_v[2]),
    .ready(ready_v[2]), .done(done_v[2]), .bcd(bcd_s), .neg(neg_v[2]), .overflow(ovf_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: magnitude as an integer, reduced modulo 10^digits, split by repeated division.
  task automatic model(input int which, input logic [31:0] v,
                       output logic [39:0] eb, output logic en, output logic eo);
    longint mag;
    longint lim;
    longint m;
    int     digits;
    digits = (which == 2) ? 2 : 10;
    if (which == 2)                mag = longint'(v[7:0]);
    else if (which == 0 && v[31])  mag = 64'sd4294967296 - longint'(v);
    else                           mag = longint'(v);
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    eo = (mag >= lim);
    en = (which == 0) && v[31];
    m  = mag % lim;
    eb = '0;
    for (int i = 0; i < digits; i++) begin
      eb[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
  endtask

  task automatic conv(input int which, input logic [31:0] v, input int poke_at, input logic [31:0] poke_v);
    logic [39:0] eb;
    logic [39:0] prev;
    logic        en;
    logic        eo;
    int          n;
    int          bits;
    bit          held;
    bit          got_done;
    bits = (which == 2) ? 8 : 32;
    model(which, v, eb, en, eo);
    @(negedge clk);
    value_v[which] = v;
    start_v[which] = 1'b1;
    @(posedge clk); #1;
    chk("accept_ready", ready_v[which], 0);
    chk("done_one_cycle", done_v[which], 0);
    start_v[which] = 1'b0;
    prev     = bcd_v[which];
    held     = 1'b1;
    got_done = 1'b0;
    n        = 0;
    while (n < 200 && !got_done) begin
      @(posedge clk); #1;
      n++;
      start_v[which] = 1'b0;
      if (done_v[which]) begin
        got_done = 1'b1;
      end else begin
        if (bcd_v[which] !== prev) held = 1'b0;
        if (n == poke_at) begin
          value_v[which] = poke_v;
          start_v[which] = 1'b1;
        end
      end
    end
    start_v[which] = 1'b0;
    if (!got_done) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("latency", n, bits + 1);
      chk("bcd", bcd_v[which], eb);
      chk("neg", neg_v[which], en);
      chk("overflow", ovf_v[which], eo);
      chk("ready_after", ready_v[which], 1);
      chk("hold", held, 1);
    end
  endtask

  initial begin
    int          saw_done;
    int          which;
    logic [31:0] rv;
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    start_v = '0;
    value_v = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready_v[0], 1);
    chk("rst_done", done_v[0], 0);
    chk("rst_bcd", bcd_v[0], 0);
    chk("rst_neg", neg_v[0], 0);
    chk("rst_ovf", ovf_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases; consecutive calls start in the done cycle of the previous one.
    conv(0, 32'h000004D2, 0, 0);
    conv(0, 32'hFFFFFFF9, 0, 0);
    conv(0, 32'h00000000, 0, 0);
    conv(0, 32'h80000000, 0, 0);
    conv(0, 32'h7FFFFFFF, 0, 0);
    conv(0, 32'h000004D2, 5, 32'h00012345);
    conv(1, 32'hFFFFFFFF, 0, 0);
    conv(1, 32'h00000000, 0, 0);
    conv(2, 32'd100, 0, 0);
    conv(2, 32'd99, 0, 0);
    conv(2, 32'd255, 0, 0);
    conv(2, 32'd0, 0, 0);

    // Abort mid-conversion with reset.
    @(negedge clk);
    value_v[0] = 32'd98765;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", ready_v[0], 1);
    chk("abort_bcd", bcd_v[0], 0);
    chk("abort_done", done_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_v[0]) saw_done++;
    end
    chk("abort_no_done", saw_done, 0);
    chk("abort_idle_ready", ready_v[0], 1);

    // Random values across all three configurations, biased toward small and edge magnitudes.
    for (int k = 0; k < 30; k++) begin
      which = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0:       rv = $urandom_range(0, 200);
        1:       rv = 32'hFFFFFFFF - $urandom_range(0, 200);
        default: rv = $urandom;
      endcase
      conv(which, rv, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd.md
Name: bin_to_bcd

Overview:
Sequential double-dabble converter directly downstream of the calculator's divider, or of any arithmetic unit that produces a BITS-wide signed result.
- Takes one BITS-wide result (quotient or remainder, as selected at top level) and produces a sign flag plus DIGITS packed BCD digits for the display driver.
- Uses a start/ready handshake that mirrors the divider's input_vld/output_vld pair. The top level pulses start when the divider's output_vld returns high.

Parameters:
BITS, 32, width of input value; must be 4..32
DIGITS, 10, number of BCD output digits; 10 covers 32-bit magnitudes
SIGNED, 1, 1 = value is two's complement, 0 = value is unsigned

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
value  input  BITS  number to convert; sampled only on an accepted start
start  input  1  request conversion; accepted only when ready=1
ready  output  1  1 = idle, can accept start
done  output  1  one-cycle pulse: bcd/neg/overflow just updated
bcd  output  4*DIGITS  packed digits; digit 0 (units) is in [3:0]
neg  output  1  1 = value was negative (SIGNED=1 only)
overflow  output  1  1 = magnitude needed more than DIGITS digits; bcd holds the low digits

Behaviour:
- Reset (async assert, sync release):
  - Outputs: ready=1, done=0, bcd=0, neg=0, overflow=0.
  - State: IDLE; working registers cleared.
- States: IDLE, SHIFT, FINISH.
- IDLE: ready=1. On start=1, on a rising edge:
  - Latch mag = |value|. When SIGNED=0, or the MSB is 0, mag = value; otherwise mag = ~value+1 taken as unsigned BITS. The most-negative value yields magnitude 2^(BITS-1) with no loss.
  - Latch sign_w = SIGNED & value[BITS-1].
  - Clear the working BCD register and the sticky ovf_w.
  - Set cnt=BITS; go to SHIFT; ready drops on the same edge.
- SHIFT, one step per cycle:
  - Adjust: each working digit >= 5 gets +3.
  - Shift {digits, mag} left by 1.
  - If the adjusted top digit's bit 3 is 1, set ovf_w; it is sticky.
  - cnt decrements each step. Leave for FINISH on the edge where cnt reaches 0, i.e. after exactly BITS steps.
- FINISH, one cycle:
  - Copy working digits to bcd, sign_w to neg, ovf_w to overflow.
  - done=1 for this cycle only; go to IDLE; ready=1 again from the next cycle.
- Latency:
  - start accepted at edge 0; bcd/neg/overflow updated and done asserted in the cycle after edge BITS+1 (BITS+2 cycles start-to-done).
  - Next start is accepted at the earliest on the edge that ends the done cycle.
- Output registers change only in FINISH and hold their values through the whole next conversion, so the display never shows intermediate values.
- start while ready=0 is ignored; there is no queue. value changing while busy has no effect.
- Zero input: bcd=0, neg=0, overflow=0. Two's-complement zero never reports neg=1.
- rst_n asserted mid-conversion aborts immediately; done is not produced.

Decomposition:
- Shared package calc_pkg:
  - state encodings IDLE/SHIFT/FINISH, also usable by the divider's state machine;
  - BCD_W=4 digit width constant;
  - function digits_for_bits(bits) for top-level DIGITS sizing.
- One sub-module, bcd_add3: combinational 4-bit "if >=5 add 3" cell, instantiated DIGITS times via generate.

Test Plan:
- value=0x000004D2 (1234), SIGNED=1 -> after 34 cycles done pulse; bcd=0x0000001234, neg=0, overflow=0; ready high next cycle.
- value=0xFFFFFFF9 (-7) -> bcd=0x0000000007, neg=1; then value=0 -> bcd=0, neg=0.
- value=0x80000000 -> bcd=0x2147483648, neg=1, overflow=0; value=0x7FFFFFFF -> bcd=0x2147483647, neg=0.
- SIGNED=0, value=0xFFFFFFFF -> bcd=0x4294967295, neg=0, overflow=0.
- DIGITS=2, BITS=8, SIGNED=0, value=100 -> overflow=1, bcd=0x00; value=99 -> overflow=0, bcd=0x99.
- Robustness:
  - Second start plus new value at cycle 5 of a conversion -> ignored; result matches the first value.
  - rst_n low at cycle 10 -> ready=1, bcd=0, no done pulse.
  - A new start in the cycle after done -> accepted, with the previous bcd held until the new FINISH.
